// File: rtl/stopwatch_pkg.sv
// Shared types, limits and helpers for the stopwatch_timer slice.
package stopwatch_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t SEC_L_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX = 4'd9;

    // Count direction, taken straight from the mode_down pin
    typedef enum logic {
        MODE_UP   = 1'b0,
        MODE_DOWN = 1'b1
    } count_mode_e;

    // Display order: {min_l, min_r, sec_l, sec_r}
    typedef struct packed {
        bcd_t min_l;
        bcd_t min_r;
        bcd_t sec_l;
        bcd_t sec_r;
    } bcd_time_t;

    // Saturate a BCD digit to an upper limit
    function automatic bcd_t bcd_clamp(input bcd_t val, input bcd_t max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/stopwatch_timer_bcd_digit.sv
// One mod-(n+1) BCD digit counting up or down, with synchronous load.
// carry/borrow flag that this digit rolls over on the current enable,
// so the next digit can be enabled from them in the same cycle.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic dir,
    input  logic ld,
    input  bcd_t ld_val,
    input  bcd_t n,
    output bcd_t q,
    output logic carry,
    output logic borrow
);

    // Digit register: load has priority over counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= ld_val;
        end else if (en) begin
            if (dir == MODE_DOWN) begin
                q <= (q == '0) ? n : q - bcd_t'(1);
            end else begin
                q <= (q >= n) ? '0 : q + bcd_t'(1);
            end
        end
    end

    assign carry  = en && (dir == MODE_UP)   && (q >= n);
    assign borrow = en && (dir == MODE_DOWN) && (q == '0);

endmodule

// File: rtl/stopwatch_timer.sv
// MM:SS BCD stopwatch / countdown timer with internal tick prescaler.
// Optional lap freeze is built when STOPWATCH_LAP_EN is defined; otherwise
// lap is ignored and lap_active is tied low.
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned DIGIT_W  = 5,
    parameter int unsigned MAX_MIN  = 99,
    parameter bit          WRAP     = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               paused,
    input  logic               mode_down,
    input  logic               load,
    input  logic [15:0]        load_bcd,
    input  logic               lap,
    output logic [DIGIT_W-1:0] min_l,
    output logic [DIGIT_W-1:0] min_r,
    output logic [DIGIT_W-1:0] sec_l,
    output logic [DIGIT_W-1:0] sec_r,
    output logic               tick,
    output logic               done,
    output logic               lap_active
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam bcd_t MAX_ML = bcd_t'(MAX_MIN / 10);
    localparam bcd_t MAX_MR = bcd_t'(MAX_MIN % 10);

    localparam bcd_time_t TERM_TIME = '{min_l: MAX_ML, min_r: MAX_MR,
                                        sec_l: SEC_L_MAX, sec_r: DIGIT_MAX};
    localparam bcd_time_t ONE_TIME  = '{min_l: 4'd0, min_r: 4'd0,
                                        sec_l: 4'd0, sec_r: 4'd1};

    logic [PRE_W-1:0] pre;
    logic             tick_i;
    count_mode_e      dir;

    bcd_time_t        live;
    bcd_time_t        shown;
    bcd_time_t        ld_time;
    bcd_time_t        dig_val;

    bcd_t             q_ml, q_mr, q_sl, q_sr;
    logic             c_sr, b_sr, c_sl, b_sl, c_mr, b_mr;
    logic             unused_ml_carry, unused_ml_borrow;

    logic             at_term, at_zero, at_one, at_stop;
    logic             wrap_ld, cnt_en, dig_ld;

    // Prescaler: free-running unless paused; load restarts the period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (load) begin
            pre <= '0;
        end else if (!paused) begin
            pre <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
        end
    end

    assign tick_i = (pre == PRE_LAST) && !paused;
    assign tick   = tick_i;
    assign dir    = mode_down ? MODE_DOWN : MODE_UP;

    // Preset clamping: each digit to 9, tens of seconds to 5, minutes to MAX_MIN
    always_comb begin
        ld_time.sec_r = bcd_clamp(load_bcd[3:0],   DIGIT_MAX);
        ld_time.sec_l = bcd_clamp(load_bcd[7:4],   SEC_L_MAX);
        ld_time.min_r = bcd_clamp(load_bcd[11:8],  DIGIT_MAX);
        ld_time.min_l = bcd_clamp(load_bcd[15:12], DIGIT_MAX);
        if ((ld_time.min_l > MAX_ML) ||
            ((ld_time.min_l == MAX_ML) && (ld_time.min_r > MAX_MR))) begin
            ld_time.min_l = MAX_ML;
            ld_time.min_r = MAX_MR;
        end
    end

    assign live    = '{min_l: q_ml, min_r: q_mr, sec_l: q_sl, sec_r: q_sr};
    assign at_term = (live == TERM_TIME);
    assign at_zero = (live == '0);
    assign at_one  = (live == ONE_TIME);
    assign at_stop = (dir == MODE_UP) ? at_term : at_zero;

    // Terminal handling stays out of the digit chain: counting is gated at the
    // end points, and the up-mode wrap reuses the digit load path with zero.
    assign wrap_ld = tick_i && (dir == MODE_UP) && at_term && WRAP;
    assign cnt_en  = tick_i && !load && !at_stop;
    assign dig_ld  = load || wrap_ld;
    assign dig_val = load ? ld_time : '0;

    bcd_digit u_sec_r (
        .clk    (clk),
        .rst    (rst),
        .en     (cnt_en),
        .dir    (dir),
        .ld     (dig_ld),
        .ld_val (dig_val.sec_r),
        .n      (DIGIT_MAX),
        .q      (q_sr),
        .carry  (c_sr),
        .borrow (b_sr)
    );

    bcd_digit u_sec_l (
        .clk    (clk),
        .rst    (rst),
        .en     (c_sr | b_sr),
        .dir    (dir),
        .ld     (dig_ld),
        .ld_val (dig_val.sec_l),
        .n      (SEC_L_MAX),
        .q      (q_sl),
        .carry  (c_sl),
        .borrow (b_sl)
    );

    bcd_digit u_min_r (
        .clk    (clk),
        .rst    (rst),
        .en     (c_sl | b_sl),
        .dir    (dir),
        .ld     (dig_ld),
        .ld_val (dig_val.min_r),
        .n      (DIGIT_MAX),
        .q      (q_mr),
        .carry  (c_mr),
        .borrow (b_mr)
    );

    bcd_digit u_min_l (
        .clk    (clk),
        .rst    (rst),
        .en     (c_mr | b_mr),
        .dir    (dir),
        .ld     (dig_ld),
        .ld_val (dig_val.min_l),
        .n      (DIGIT_MAX),
        .q      (q_ml),
        .carry  (unused_ml_carry),
        .borrow (unused_ml_borrow)
    );

    // Sticky terminal flag: set on a tick at the end point or on reaching 00:00
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else if (load) begin
            done <= 1'b0;
        end else if (tick_i && (at_stop || ((dir == MODE_DOWN) && at_one))) begin
            done <= 1'b1;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic      lap_q;
    bcd_time_t snap;

    // Lap freeze: capture the live count when entering, release when leaving
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_q <= 1'b0;
            snap  <= '0;
        end else if (load) begin
            lap_q <= 1'b0;
        end else if (lap) begin
            lap_q <= !lap_q;
            if (!lap_q) begin
                snap <= live;
            end
        end
    end

    assign shown      = lap_q ? snap : live;
    assign lap_active = lap_q;
`else
    logic unused_lap;

    assign unused_lap = lap;
    assign shown      = live;
    assign lap_active = 1'b0;
`endif

    assign min_l = DIGIT_W'(shown.min_l);
    assign min_r = DIGIT_W'(shown.min_r);
    assign sec_l = DIGIT_W'(shown.sec_l);
    assign sec_r = DIGIT_W'(shown.sec_r);

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed bench for stopwatch_timer with TICK_DIV=2, MAX_MIN=99.
// Two instances share stimulus: u_dut saturates, u_dut_w wraps.
module tb_stopwatch_timer;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        paused;
    logic        mode_down;
    logic        load;
    logic [15:0] load_bcd;
    logic        lap;

    logic [4:0]  min_l, min_r, sec_l, sec_r;
    logic        tick, done, lap_active;
    logic [4:0]  w_min_l, w_min_r, w_sec_l, w_sec_r;
    logic        w_tick, w_done, w_lap_active;

    logic [15:0] disp, w_disp;
    logic [3:0]  upper;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stopwatch_timer #(
        .TICK_DIV (2),
        .DIGIT_W  (5),
        .MAX_MIN  (99),
        .WRAP     (1'b0)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .paused     (paused),
        .mode_down  (mode_down),
        .load       (load),
        .load_bcd   (load_bcd),
        .lap        (lap),
        .min_l      (min_l),
        .min_r      (min_r),
        .sec_l      (sec_l),
        .sec_r      (sec_r),
        .tick       (tick),
        .done       (done),
        .lap_active (lap_active)
    );

    stopwatch_timer #(
        .TICK_DIV (2),
        .DIGIT_W  (5),
        .MAX_MIN  (99),
        .WRAP     (1'b1)
    ) u_dut_w (
        .clk        (clk),
        .rst        (rst),
        .paused     (paused),
        .mode_down  (mode_down),
        .load       (load),
        .load_bcd   (load_bcd),
        .lap        (lap),
        .min_l      (w_min_l),
        .min_r      (w_min_r),
        .sec_l      (w_sec_l),
        .sec_r      (w_sec_r),
        .tick       (w_tick),
        .done       (w_done),
        .lap_active (w_lap_active)
    );

    assign disp   = {min_l[3:0], min_r[3:0], sec_l[3:0], sec_r[3:0]};
    assign w_disp = {w_min_l[3:0], w_min_r[3:0], w_sec_l[3:0], w_sec_r[3:0]};
    assign upper  = {min_l[4], min_r[4], sec_l[4], sec_r[4]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [15:0] val);
        load_bcd = val;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        paused    = 1'b0;
        mode_down = 1'b0;
        load      = 1'b0;
        load_bcd  = '0;
        lap       = 1'b0;

        // Reset state
        cyc(2);
        check("rst_disp", disp, 16'h0000);
        check("rst_tick", tick, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_lap_active", lap_active, 1'b0);
        rst = 1'b0;

        // Up count: tick on every 2nd edge, ripple through all carries
        cyc(1);
        check("up_tick_hi", tick, 1'b1);
        cyc(1);
        check("up_tick_lo", tick, 1'b0);
        check("up_first", disp, 16'h0001);
        cyc(18);
        check("up_10s", disp, 16'h0010);
        cyc(100);
        check("up_60s", disp, 16'h0100);
        cyc(120);
        check("up_120s", disp, 16'h0200);
        check("up_done", done, 1'b0);
        check("upper_zero", upper, 4'h0);

        // Countdown to zero, then a tick at 00:00
        mode_down = 1'b1;
        pulse_load(16'h0005);
        check("dn_load", disp, 16'h0005);
        cyc(8);
        check("dn_one", disp, 16'h0001);
        check("dn_one_done", done, 1'b0);
        cyc(2);
        check("dn_zero", disp, 16'h0000);
        check("dn_zero_done", done, 1'b1);
        cyc(2);
        check("dn_hold", disp, 16'h0000);
        check("dn_hold_done", done, 1'b1);

        // Borrow across all digits; load clears done
        pulse_load(16'h1000);
        check("dn_load_clr_done", done, 1'b0);
        cyc(2);
        check("dn_borrow", disp, 16'h0959);

        // Up terminal: saturate vs wrap
        mode_down = 1'b0;
        pulse_load(16'h9958);
        cyc(2);
        check("term_pre", disp, 16'h9959);
        check("term_pre_done", done, 1'b0);
        check("wrap_pre", w_disp, 16'h9959);
        cyc(2);
        check("term_sat", disp, 16'h9959);
        check("term_sat_done", done, 1'b1);
        check("wrap_zero", w_disp, 16'h0000);
        check("wrap_done", w_done, 1'b1);
        cyc(2);
        check("term_sat_hold", disp, 16'h9959);
        check("wrap_continue", w_disp, 16'h0001);
        check("wrap_done_sticky", w_done, 1'b1);

        // Async reset between edges clears outputs at once
        #2 rst = 1'b1;
        #1;
        check("arst_disp", disp, 16'h0000);
        check("arst_done", done, 1'b0);
        check("arst_wrap_disp", w_disp, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Pause with prescaler at its last value
        pulse_load(16'h0000);
        cyc(1);
        check("pause_pre_tick", tick, 1'b1);
        paused = 1'b1;
        #1;
        check("pause_tick_gated", tick, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            check("pause_no_tick", tick, 1'b0);
        end
        check("pause_frozen", disp, 16'h0000);
        paused = 1'b0;
        #1;
        check("resume_tick", tick, 1'b1);
        cyc(1);
        check("resume_count", disp, 16'h0001);

        // Clamp and load-over-tick priority
        pulse_load(16'hAB7C);
        check("clamp", disp, 16'h9959);
        pulse_load(16'h0000);
        cyc(1);
        check("ld_tick_pre", tick, 1'b1);
        pulse_load(16'h1234);
        check("ld_over_tick", disp, 16'h1234);
        check("ld_pre_clr", tick, 1'b0);
        cyc(1);
        check("ld_after", disp, 16'h1234);

        // Lap freeze
        pulse_load(16'h0010);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        check("lap_on", lap_active, LAP);
        cyc(9);
        check("lap_frozen", disp, LAP ? 16'h0010 : 16'h0015);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        check("lap_off_disp", disp, 16'h0015);
        check("lap_off", lap_active, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
